// File: rtl/fft_frame_serializer.sv
// Double-banked N-point FFT frame serializer: parallel frame in, one indexed sample per beat out.
// Optional imaginary-sign conjugation per frame is enabled by defining FFT_SER_CONJ_EN.
module fft_frame_serializer #(
    parameter int N = 8,
    parameter int W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N*W-1:0]         in_data,
    input  logic                   in_valid,
    input  logic                   in_bitrev,
    output logic                   in_ready,
    output logic [$clog2(N)+W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
`ifdef FFT_SER_CONJ_EN
    input  logic                   conj_en,
`endif
    output logic                   done
);
    localparam int LOGN = $clog2(N);

    logic [N*W-1:0]  bank_q [2];
    logic [N*W-1:0]  bank_d [2];
    logic [1:0]      brev_q, brev_d;
    logic [1:0]      conj_q, conj_d;
    logic [1:0]      full_q, full_d;
    logic            wr_sel_q, wr_sel_d;
    logic            rd_sel_q, rd_sel_d;
    logic [LOGN-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;

    logic [LOGN-1:0] rev_cnt;
    logic [LOGN-1:0] rd_idx;
    logic [W-1:0]    rd_sample;
    logic [W-1:0]    imag_sign;
    logic            capture;
    logic            accept;
    logic            cnt_at_last;
    logic            conj_in;

`ifdef FFT_SER_CONJ_EN
    assign conj_in = conj_en;
`else
    assign conj_in = 1'b0;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < LOGN; gi++) begin : g_rev
            assign rev_cnt[gi] = cnt_q[LOGN-1-gi];
        end
    endgenerate

    assign imag_sign   = {{(W/2){1'b0}}, 1'b1, {(W/2-1){1'b0}}};
    assign rd_idx      = brev_q[rd_sel_q] ? rev_cnt : cnt_q;
    assign rd_sample   = bank_q[rd_sel_q][rd_idx*W +: W] ^ (conj_q[rd_sel_q] ? imag_sign : '0);
    assign cnt_at_last = (cnt_q == LOGN'(N-1));

    assign in_ready  = !full_q[wr_sel_q] && !reset;
    assign out_valid = full_q[rd_sel_q] && !reset;
    assign out_last  = out_valid && cnt_at_last;
    assign out_data  = {cnt_q, rd_sample};
    assign done      = done_q;

    assign capture = in_valid && in_ready;
    assign accept  = out_valid && out_ready;

    always_comb begin
        bank_d   = bank_q;
        brev_d   = brev_q;
        conj_d   = conj_q;
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        // Capture and release can coincide; they never address the same bank.
        if (capture) begin
            bank_d[wr_sel_q] = in_data;
            brev_d[wr_sel_q] = in_bitrev;
            conj_d[wr_sel_q] = conj_in;
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
        end
        if (accept) begin
            if (cnt_at_last) begin
                cnt_d            = '0;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
                done_d           = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            brev_q   <= '0;
            conj_q   <= '0;
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            brev_q   <= brev_d;
            conj_q   <= conj_d;
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    // Bank contents need no reset; validity is tracked by full_q.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                bank_q[gi] <= bank_d[gi];
            end
        end
    endgenerate
endmodule

// File: tb/tb_fft_frame_serializer.sv
// Randomized bench for fft_frame_serializer against a frame-queue reference model.
// Also exercises the conjugation option when FFT_SER_CONJ_EN is defined.
module tb_fft_frame_serializer;
    localparam int N    = 8;
    localparam int W    = 32;
    localparam int LOGN = $clog2(N);

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [N*W-1:0]      in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_bitrev = 1'b0;
    logic                in_ready;
    logic [LOGN+W-1:0]   out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                out_last;
    logic                done;
    logic                conj_sel = 1'b0;

    fft_frame_serializer #(.N(N), .W(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_bitrev(in_bitrev),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
`ifdef FFT_SER_CONJ_EN
        .conj_en(conj_sel),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N*W-1:0] data;
        logic           brev;
        logic           conj;
    } frame_t;

    frame_t      mq[$];
    logic [63:0] log_q[$];
    int          pos = 0;
    bit          done_exp = 1'b0;
    int          done_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic int bitrev(int k);
        int r = 0;
        for (int i = 0; i < LOGN; i++) r = r | (((k >> i) & 1) << (LOGN - 1 - i));
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: frames wait in a queue (capacity 2); the head streams in natural index order.
    logic        e_valid, e_ready, e_last;
    logic [63:0] e_data;
    logic [W-1:0] e_smp;
    int          e_j;
    always @(negedge clk) begin
        e_valid = !reset && mq.size() > 0;
        e_ready = !reset && mq.size() < 2;
        e_last  = e_valid && pos == N - 1;
        e_data  = '0;
        if (e_valid) begin
            e_j   = mq[0].brev ? bitrev(pos) : pos;
            e_smp = mq[0].data[e_j*W +: W];
            if (mq[0].conj) e_smp[W/2-1] = ~e_smp[W/2-1];
            e_data = (64'(pos) << W) | 64'(e_smp);
        end
        check("out_valid", 64'(out_valid), 64'(e_valid));
        check("in_ready", 64'(in_ready), 64'(e_ready));
        check("out_last", 64'(out_last), 64'(e_last));
        check("done", 64'(done), 64'(done_exp));
        if (e_valid) check("out_data", 64'(out_data), e_data);
        if (done) done_cnt++;
        if (reset) begin
            mq.delete();
            pos      = 0;
            done_exp = 1'b0;
        end else begin
            done_exp = 1'b0;
            if (e_valid && out_ready) begin
                log_q.push_back(64'(out_data));
                if (pos == N - 1) begin
                    void'(mq.pop_front());
                    pos      = 0;
                    done_exp = 1'b1;
                end else begin
                    pos++;
                end
            end
            if (in_valid && e_ready) mq.push_back('{data: in_data, brev: in_bitrev, conj: conj_sel});
        end
    end

    task automatic offer(input logic [N*W-1:0] d, input logic br, input logic cj, output int waited);
        bit got = 1'b0;
        in_data   = d;
        in_bitrev = br;
        conj_sel  = cj;
        in_valid  = 1'b1;
        waited    = 0;
        while (!got && waited < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!got) check("offer_timeout", 64'(waited), 64'(0));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int c = 0;
        while ((mq.size() > 0 || done_exp) && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        @(posedge clk);
        #1;
        if (c >= 1000) check("drain_timeout", 64'(c), 64'(0));
    endtask

    logic [N*W-1:0] fr;
    int             w;
    int             base;
    int             dbase;
    bit             rnd_on;
    int             vals[N] = '{32'h3c000000, 32'h40000000, 32'h42000000, 32'h44000000,
                                32'h44000000, 32'h42000000, 32'h40000000, 32'h3c000000};
    int             brseq[N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

        // Natural-order frame 1,2,3,4,4,3,2,1
        out_ready = 1'b1;
        for (int k = 0; k < N; k++) fr[k*W +: W] = W'(vals[k]);
        base = log_q.size();
        dbase = done_cnt;
        offer(fr, 1'b0, 1'b0, w);
        drain();
        check("nat_beat0", log_q[base], {32'd0, 32'h3c000000});
        check("nat_beat3", log_q[base+3], {32'd3, 32'h44000000});
        check("nat_beat7", log_q[base+7], {32'd7, 32'h3c000000});
        check("nat_done", 64'(done_cnt - dbase), 64'd1);

        // Bit-reversed input
        for (int k = 0; k < N; k++) fr[k*W +: W] = W'(32'h1000 + k);
        base = log_q.size();
        offer(fr, 1'b1, 1'b0, w);
        drain();
        for (int k = 0; k < N; k++)
            check("brev_beat", log_q[base+k], (64'(k) << 32) | 64'(32'h1000 + brseq[k]));

        // Three frames with downstream stalled
        out_ready = 1'b0;
        base = log_q.size();
        dbase = done_cnt;
        for (int k = 0; k < N; k++) fr[k*W +: W] = W'(32'h2000 + k);
        offer(fr, 1'b0, 1'b0, w);
        for (int k = 0; k < N; k++) fr[k*W +: W] = W'(32'h3000 + k);
        offer(fr, 1'b0, 1'b0, w);
        for (int k = 0; k < N; k++) fr[k*W +: W] = W'(32'h4000 + k);
        in_data  = fr;
        in_valid = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("both_full_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        offer(fr, 1'b0, 1'b0, w);
        check("third_capture_wait", 64'(w), 64'd9);
        drain();
        check("three_beats", 64'(log_q.size() - base), 64'd24);
        check("three_done", 64'(done_cnt - dbase), 64'd3);
        check("three_b8", log_q[base+8], {32'd0, 32'h3000});
        check("three_b23", log_q[base+23], {32'd7, 32'h4007});

        // Random frames with random backpressure
        rnd_on = 1'b1;
        base = log_q.size();
        dbase = done_cnt;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    for (int k = 0; k < N; k++) fr[k*W +: W] = W'($urandom);
                    offer(fr, 1'($urandom), 1'b0, w);
                    repeat ($urandom_range(0, 6)) @(posedge clk);
                    #1;
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("rand_beats", 64'(log_q.size() - base), 64'(30 * N));
        check("rand_done", 64'(done_cnt - dbase), 64'd30);

        // Reset mid-stream with a queued frame
        dbase = done_cnt;
        for (int k = 0; k < N; k++) fr[k*W +: W] = W'(32'h5000 + k);
        offer(fr, 1'b0, 1'b0, w);
        offer(fr, 1'b0, 1'b0, w);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_no_done", 64'(done_cnt - dbase), 64'd0);
        @(posedge clk);
        #1;
        base = log_q.size();
        for (int k = 0; k < N; k++) fr[k*W +: W] = W'(32'h6000 + k);
        offer(fr, 1'b0, 1'b0, w);
        drain();
        check("rst_restart_b0", log_q[base], {32'd0, 32'h6000});
        check("rst_restart_done", 64'(done_cnt - dbase), 64'd1);

`ifdef FFT_SER_CONJ_EN
        for (int k = 0; k < N; k++) fr[k*W +: W] = 32'h3c003c00;
        base = log_q.size();
        offer(fr, 1'b0, 1'b1, w);
        offer(fr, 1'b0, 1'b0, w);
        drain();
        check("conj_on", log_q[base], {32'd0, 32'h3c00bc00});
        check("conj_off", log_q[base+N], {32'd0, 32'h3c003c00});
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
